// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a mid-bit sampler, false-start rejection and a frame-error pulse
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP, WAIT_HIGH} state_e;
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
  logic       rx_meta_q, rx_s_q;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, data_q, data_d, byte_q, byte_d;
  logic [2:0] idx_q, idx_d;
  logic       dv_q, dv_d, ferr_q, ferr_d, act_q, act_d;
  // two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
    end
  end
  // state, counters, data and output registers
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
      act_q   <= act_d;
    end
  end
  // next-state: pulses default low so each lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    act_d   = act_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
          act_d   = !rx_s_q;
        end else cnt_d = cnt_q + 8'd1;
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d         = '0;
          data_d[idx_q] = rx_s_q;
          idx_d         = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else cnt_d = cnt_q + 8'd1;
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          act_d = 1'b0;
          if (rx_s_q) begin
            byte_d  = data_q;
            dv_d    = 1'b1;
            state_d = CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else cnt_d = cnt_q + 8'd1;
      end
      CLEANUP: state_d = IDLE;
      WAIT_HIGH: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = ferr_q;
  assign o_Rx_Active    = act_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench; a behavioural serial transmitter feeds the receiver and queues expected bytes
module tb_uart_rx;
  localparam int CPB = 8;
  logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic       dv, ferr, act;
  logic [7:0] rx_byte;
  int         errors = 0, checks = 0;
  logic [7:0] got_q[$], exp_q[$];
  int         ferr_n = 0, both_n = 0, wide_n = 0, act_n = 0;
  logic [7:0] ferr_byte = 8'h00;
  logic       dv_p = 1'b0, fe_p = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx),
    .o_Rx_DV(dv), .o_Rx_Byte(rx_byte), .o_Rx_Frame_Err(ferr), .o_Rx_Active(act)
  );

  always #5 clk = ~clk;

  // observe outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (dv) got_q.push_back(rx_byte);
    if (ferr) begin ferr_n++; ferr_byte = rx_byte; end
    if (dv && ferr) both_n++;
    if ((dv && dv_p) || (ferr && fe_p)) wide_n++;
    if (act) act_n++;
    dv_p = dv;
    fe_p = ferr;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // reference transmitter: start, 8 data LSB first, stop; even/odd bits last pa/pb cycles
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pa, input int pb);
    for (int i = 0; i < 10; i++)
      send_bit(i == 0 ? 1'b0 : (i == 9 ? stop : b[i-1]), (i % 2 == 0) ? pa : pb);
    if (stop) exp_q.push_back(b);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({dv, ferr, act} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {dv, ferr, act}); end
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", rx_byte); end
    rst_n = 1'b1;
    got_q.delete(); exp_q.delete();
    send_bit(1'b1, 20);
    checks++; if (got_q.size() != 0 || ferr_n != 0 || act_n != 0) begin errors++; $display("FAIL idle_quiet: got dv=%0d ferr=%0d act=%0d expected 0 0 0", got_q.size(), ferr_n, act_n); end
  endtask

  task automatic test_frame_a5;
    int a0, f0;
    got_q.delete(); exp_q.delete();
    a0 = act_n; f0 = ferr_n;
    send_frame(8'hA5, 1'b1, CPB, CPB);
    send_bit(1'b1, 2 * CPB);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL a5_count: got %0d pulses expected 1", got_q.size()); end
    else begin checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL a5_byte: got %h expected %h", got_q[0], exp_q[0]); end end
    checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL a5_hold: got %h expected a5", rx_byte); end
    checks++; if (ferr_n != f0) begin errors++; $display("FAIL a5_ferr: got %0d expected %0d", ferr_n, f0); end
    checks++; if (act_n - a0 != 9 * CPB) begin errors++; $display("FAIL a5_active: got %0d cycles expected %0d", act_n - a0, 9 * CPB); end
  endtask

  task automatic test_glitch;
    int a0, f0;
    got_q.delete(); exp_q.delete();
    a0 = act_n; f0 = ferr_n;
    send_bit(1'b0, 3);
    send_bit(1'b1, 4 * CPB);
    checks++; if (got_q.size() != 0 || ferr_n != f0) begin errors++; $display("FAIL glitch_pulse: got dv=%0d ferr=%0d expected 0 0", got_q.size(), ferr_n - f0); end
    checks++; if (act_n != a0) begin errors++; $display("FAIL glitch_active: got %0d cycles expected 0", act_n - a0); end
    send_frame(8'h3E, 1'b1, CPB, CPB);
    send_bit(1'b1, 2 * CPB);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h3E) begin errors++; $display("FAIL glitch_recover: got %0d pulses last %h expected 1 pulse 3e", got_q.size(), rx_byte); end
  endtask

  task automatic test_frame_err;
    int f0;
    got_q.delete(); exp_q.delete();
    send_frame(8'h96, 1'b1, CPB, CPB);
    send_bit(1'b1, 2 * CPB);
    f0 = ferr_n;
    send_frame(8'h3C, 1'b0, CPB, CPB);
    send_bit(1'b0, 40);
    checks++; if (ferr_n - f0 != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_n - f0); end
    checks++; if (ferr_byte !== 8'h96) begin errors++; $display("FAIL ferr_byte_held: got %h expected 96", ferr_byte); end
    send_bit(1'b1, 2 * CPB);
    checks++; if (ferr_n - f0 != 1 || got_q.size() != 1) begin errors++; $display("FAIL break_quiet: got ferr=%0d dv=%0d expected 1 1", ferr_n - f0, got_q.size()); end
    checks++; if (rx_byte !== 8'h96) begin errors++; $display("FAIL ferr_hold: got %h expected 96", rx_byte); end
    send_frame(8'h5A, 1'b1, CPB, CPB);
    send_bit(1'b1, 2 * CPB);
    checks++; if (got_q.size() != 2 || got_q[$] !== 8'h5A) begin errors++; $display("FAIL after_break: got %0d pulses last %h expected 2 pulses 5a", got_q.size(), rx_byte); end
  endtask

  task automatic test_reset_mid;
    int f0;
    got_q.delete(); exp_q.delete();
    f0 = ferr_n;
    send_bit(1'b0, CPB);
    send_bit(1'b1, 4 * CPB + CPB / 2);
    rst_n = 1'b0;
    #1;
    checks++; if ({dv, ferr, act} !== 3'b000 || rx_byte !== 8'h00) begin errors++; $display("FAIL midreset_outputs: got flags=%b byte=%h expected 000 00", {dv, ferr, act}, rx_byte); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1, 6 * CPB);
    checks++; if (got_q.size() != 0 || ferr_n != f0) begin errors++; $display("FAIL midreset_discard: got dv=%0d ferr=%0d expected 0 0", got_q.size(), ferr_n - f0); end
    send_frame(8'h81, 1'b1, CPB, CPB);
    send_bit(1'b1, 2 * CPB);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h81) begin errors++; $display("FAIL midreset_resume: got %0d pulses last %h expected 1 pulse 81", got_q.size(), rx_byte); end
  endtask

  task automatic test_back_to_back;
    int f0;
    got_q.delete(); exp_q.delete();
    f0 = ferr_n;
    send_frame(8'h00, 1'b1, CPB, CPB);
    send_frame(8'hFF, 1'b1, CPB, CPB);
    send_frame(8'h55, 1'b1, CPB, CPB);
    for (int i = 0; i < 6; i++) send_frame(8'($urandom), 1'b1, CPB, CPB);
    send_bit(1'b1, 3 * CPB);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (ferr_n != f0) begin errors++; $display("FAIL b2b_ferr: got %0d expected 0", ferr_n - f0); end
  endtask

  task automatic test_random;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      send_frame(8'($urandom), 1'b1, CPB, CPB);
      send_bit(1'b1, $urandom_range(1, 3 * CPB));
    end
    send_bit(1'b1, 2 * CPB);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_skew;
    got_q.delete(); exp_q.delete();
    send_frame(8'hC3, 1'b1, CPB - 1, CPB + 1);
    send_bit(1'b1, 2 * CPB);
    send_frame(8'hC3, 1'b1, CPB + 1, CPB - 1);
    send_bit(1'b1, 2 * CPB);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL skew_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL skew_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_frame_a5;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    test_back_to_back;
    test_random;
    test_skew;
    checks++; if (both_n != 0 || wide_n != 0) begin errors++; $display("FAIL pulse_shape: got overlap=%0d wide=%0d expected 0 0", both_n, wide_n); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
